axis_dpc_ctrl: RTL and testbench
================================

# axis_dpc_ctrl

Frame-synchronous configuration and stream monitor for the defective-pixel-correction stage. It holds CPU-writable pending settings (enable, threshold) and commits them to the DPC only on an accepted start-of-frame beat, so a frame is never processed with mixed settings. It also snoops the DPC input AXI4-Stream handshake to count frames, check frame geometry against WIDTH/HEIGHT, and raise a per-frame interrupt. It sits beside `axis_dpc` and drives that stage's `threshold` input and the bypass select of the surrounding mux.

## Interface
- BITS, 8, pixel/threshold width (1..16)
- WIDTH, 1280, active pixels per line
- HEIGHT, 960, lines per frame
- DEF_THRESHOLD, 32, reset value of pending and active threshold
- aclk  in  1  clock
- areset  in  1  reset: synchronous, active-high
- cfg_wr_en  in  1  register write strobe, one write per cycle
- cfg_wr_addr  in  2  write word address
- cfg_wr_data  in  32  write data
- cfg_rd_addr  in  2  read word address
- cfg_rd_data  out  32  read data, registered, 1-cycle latency
- mon_tvalid, mon_tready, mon_tlast, mon_tuser  in  1 each  snoop of DPC input stream (never driven)
- threshold  out  BITS  active threshold to DPC
- dpc_enable  out  1  active enable; 0 selects bypass
- frame_active  out  1  high while in ACTIVE state
- irq  out  1  level interrupt

## Operation
- Beat = mon_tvalid && mon_tready. Only beats advance state or counters.
- Registers:
  - addr 0 CTRL (rw): bit0 enable_pend, bit1 irq_en.
  - addr 1 THRESH (rw): [BITS-1:0] thr_pend; upper bits read 0.
  - addr 2 STATUS: bit0 frame_active (ro), bit1 sof_err, bit2 len_err, bit3 done (W1C), [31:16] frame_cnt (ro).
  - addr 3 POS (ro): [15:0] x, [31:16] y.
- FSM states:
  - WAIT_SOF (reset state): beat with tuser=1 commits threshold<=thr_pend and dpc_enable<=enable_pend, sets x=1 (or x=0, y=1 if tlast also set), then goes to ACTIVE. Beat with tuser=0 is ignored and sets sof_err.
  - ACTIVE: each beat increments x. On tlast or x==WIDTH-1, end the line: x<=0, y<=y+1. If only one of tlast / x==WIDTH-1 holds, set len_err; the line still ends.
    - End of a line with y==HEIGHT-1: frame end. frame_cnt+1 (wraps 65535->0), set done, return to WAIT_SOF.
    - Beat with tuser=1 in ACTIVE: premature SOF. Set sof_err, commit the shadows, restart with x=1, y=0, stay ACTIVE; no frame_cnt increment.
- irq = done && irq_en (registered). Clear it by writing 1 to STATUS bit3.
- Simultaneous events:
  - A THRESH/CTRL write in the same cycle as a committing SOF beat: the old pending value commits; the new value waits for the next SOF.
  - W1C in the same cycle as a set event: set wins.
  - A write to a read-only field is ignored.

## Timing
- Reset values:
  - threshold=DEF_THRESHOLD, thr_pend=DEF_THRESHOLD.
  - dpc_enable=1, enable_pend=1, irq_en=0.
  - frame_active=0, irq=0, cfg_rd_data=0, all status bits and counters 0.
  - FSM = WAIT_SOF.
- Reset asserted mid-frame: all of the above on the next edge; the next frame needs a fresh tuser.
- threshold/dpc_enable change exactly 1 cycle after the committing beat and are stable otherwise.
- frame_active, done, and frame_cnt update 1 cycle after the triggering beat; irq updates 1 cycle after done.
- Register writes take effect on the next edge. cfg_rd_data reflects the register state at the edge after cfg_rd_addr is sampled.
- Stalls (tvalid without tready, or gaps) hold all state. No combinational path from mon_* to any output.

## Test plan
- Reset, then read all 4 addresses -> CTRL=0x1, THRESH=DEF_THRESHOLD, STATUS=0, POS=0; threshold=32, dpc_enable=1, irq=0.
- WIDTH=8, HEIGHT=4. Write THRESH=0x50 mid-frame -> threshold stays 32 until the next tuser beat, is 0x50 one cycle later; frame end -> frame_cnt=1, done=1.
- irq_en=1, run a full frame with random tvalid/tready stalls -> irq rises 2 cycles after the last beat; write STATUS=0x8 -> irq=0 next cycle, done=0.
- Line of 6 beats with tlast (WIDTH=8) -> len_err=1, y advances to 1; line of 8 beats without tlast -> len_err stays 1, y advances.
- tuser at line 2 of ACTIVE -> sof_err=1, POS reads x=1, y=0, frame_cnt unchanged; beat without tuser in WAIT_SOF -> sof_err=1, no state change.
- Write CTRL enable=0 and THRESH in the same cycle as an SOF beat -> old values commit; dpc_enable=0 only after the following SOF.

Source files
------------

// File: rtl/axis_dpc_ctrl.sv
`timescale 1ns/1ps
// Frame-synchronous settings shadow and AXI4-Stream geometry monitor for the DPC stage.
// Pending settings commit only on an accepted SOF beat; frame_active mirrors the FSM state.
module axis_dpc_ctrl #(
    parameter int BITS          = 8,
    parameter int WIDTH         = 1280,
    parameter int HEIGHT        = 960,
    parameter int DEF_THRESHOLD = 32
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            cfg_wr_en,
    input  logic [1:0]      cfg_wr_addr,
    input  logic [31:0]     cfg_wr_data,
    input  logic [1:0]      cfg_rd_addr,
    output logic [31:0]     cfg_rd_data,
    input  logic            mon_tvalid,
    input  logic            mon_tready,
    input  logic            mon_tlast,
    input  logic            mon_tuser,
    output logic [BITS-1:0] threshold,
    output logic            dpc_enable,
    output logic            frame_active,
    output logic            irq
);
    localparam logic [15:0]     X_LAST  = 16'(WIDTH - 1);
    localparam logic [15:0]     Y_LAST  = 16'(HEIGHT - 1);
    localparam logic [BITS-1:0] THR_RST = BITS'(DEF_THRESHOLD);

    typedef enum logic {WAIT_SOF, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic [15:0]     x_q, x_d, y_q, y_d, frame_cnt_q, frame_cnt_d;
    logic [BITS-1:0] thr_pend_q, thr_pend_d, thr_q, thr_d;
    logic            en_pend_q, en_pend_d, en_q, en_d, irq_en_q, irq_en_d;
    logic            sof_err_q, sof_err_d, len_err_q, len_err_d, done_q, done_d;
    logic            irq_q, irq_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic            beat, x_at_end, commit, set_sof, set_len, set_done;
    logic            wr_ctrl, wr_thr, wr_stat;
    logic            unused_wr_bits;

    assign beat     = mon_tvalid && mon_tready;
    assign x_at_end = (x_q == X_LAST);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        frame_cnt_d = frame_cnt_q;
        commit      = 1'b0;
        set_sof     = 1'b0;
        set_len     = 1'b0;
        set_done    = 1'b0;
        if (beat) begin
            if (mon_tuser) begin
                // SOF in ACTIVE is a premature restart: flag it but still resync
                commit  = 1'b1;
                set_sof = (state_q == ACTIVE);
                state_d = ACTIVE;
                if (state_q == WAIT_SOF && mon_tlast) begin
                    x_d = 16'd0;
                    y_d = 16'd1;
                end else begin
                    x_d = 16'd1;
                    y_d = 16'd0;
                end
            end else if (state_q == WAIT_SOF) begin
                set_sof = 1'b1;
            end else if (mon_tlast || x_at_end) begin
                x_d     = 16'd0;
                set_len = (mon_tlast != x_at_end);
                if (y_q == Y_LAST) begin
                    y_d         = 16'd0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    set_done    = 1'b1;
                    state_d     = WAIT_SOF;
                end else begin
                    y_d = y_q + 16'd1;
                end
            end else begin
                x_d = x_q + 16'd1;
            end
        end
    end

    assign wr_ctrl = cfg_wr_en && (cfg_wr_addr == 2'd0);
    assign wr_thr  = cfg_wr_en && (cfg_wr_addr == 2'd1);
    assign wr_stat = cfg_wr_en && (cfg_wr_addr == 2'd2);

    // Commit reads the pre-edge pending values, so a same-cycle write waits for the next SOF
    assign en_pend_d  = wr_ctrl ? cfg_wr_data[0] : en_pend_q;
    assign irq_en_d   = wr_ctrl ? cfg_wr_data[1] : irq_en_q;
    assign thr_pend_d = wr_thr ? cfg_wr_data[BITS-1:0] : thr_pend_q;
    assign thr_d      = commit ? thr_pend_q : thr_q;
    assign en_d       = commit ? en_pend_q : en_q;
    assign sof_err_d  = set_sof  | (sof_err_q & ~(wr_stat & cfg_wr_data[1]));
    assign len_err_d  = set_len  | (len_err_q & ~(wr_stat & cfg_wr_data[2]));
    assign done_d     = set_done | (done_q & ~(wr_stat & cfg_wr_data[3]));
    assign irq_d      = done_q & irq_en_q;
    assign unused_wr_bits = ^cfg_wr_data[31:BITS];

    always_comb begin
        rd_data_d = 32'd0;
        case (cfg_rd_addr)
            2'd0:    rd_data_d = {30'd0, irq_en_q, en_pend_q};
            2'd1:    rd_data_d = 32'(thr_pend_q);
            2'd2:    rd_data_d = {frame_cnt_q, 12'd0, done_q, len_err_q, sof_err_q,
                                  state_q == ACTIVE};
            default: rd_data_d = {y_q, x_q};
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= WAIT_SOF;
            x_q         <= 16'd0;
            y_q         <= 16'd0;
            frame_cnt_q <= 16'd0;
            thr_pend_q  <= THR_RST;
            thr_q       <= THR_RST;
            en_pend_q   <= 1'b1;
            en_q        <= 1'b1;
            irq_en_q    <= 1'b0;
            sof_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
            done_q      <= 1'b0;
            irq_q       <= 1'b0;
            rd_data_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            frame_cnt_q <= frame_cnt_d;
            thr_pend_q  <= thr_pend_d;
            thr_q       <= thr_d;
            en_pend_q   <= en_pend_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            sof_err_q   <= sof_err_d;
            len_err_q   <= len_err_d;
            done_q      <= done_d;
            irq_q       <= irq_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign cfg_rd_data  = rd_data_q;
    assign threshold    = thr_q;
    assign dpc_enable   = en_q;
    assign frame_active = (state_q == ACTIVE);
    assign irq          = irq_q;
endmodule

// File: tb/tb_axis_dpc_ctrl.sv
`timescale 1ns/1ps
// Directed bench for axis_dpc_ctrl on an 8x4 frame; inputs driven and outputs sampled on negedge.
module tb_axis_dpc_ctrl;
    localparam int BITS = 8, WIDTH = 8, HEIGHT = 4, DEF_THR = 32;

    // clock / reset block
    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic            cfg_wr_en = 1'b0;
    logic [1:0]      cfg_wr_addr = '0;
    logic [31:0]     cfg_wr_data = '0;
    logic [1:0]      cfg_rd_addr = '0;
    logic [31:0]     cfg_rd_data;
    logic            mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0, mon_tuser = 1'b0;
    logic [BITS-1:0] threshold;
    logic            dpc_enable, frame_active, irq;
    logic [31:0]     rd;
    int              n_vec = 0;
    int              n_err = 0;

    always #5 aclk = ~aclk;

    axis_dpc_ctrl #(.BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .DEF_THRESHOLD(DEF_THR)) dut (
        .aclk(aclk), .areset(areset),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_rd_addr(cfg_rd_addr), .cfg_rd_data(cfg_rd_data),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
        .mon_tuser(mon_tuser),
        .threshold(threshold), .dpc_enable(dpc_enable), .frame_active(frame_active), .irq(irq)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // scoreboard check
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic idle_all();
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tuser = 1'b0; mon_tlast = 1'b0;
        cfg_wr_en = 1'b0;
    endtask

    task automatic beat_wr(input logic u, input logic l, input logic we,
                           input logic [1:0] a, input logic [31:0] d);
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tuser = u; mon_tlast = l;
        cfg_wr_en = we; cfg_wr_addr = a; cfg_wr_data = d;
        tick();
        idle_all();
    endtask

    task automatic beat(input logic u, input logic l);
        beat_wr(u, l, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic stall_beat(input logic u, input logic l);
        bit hs = 1'b0;
        for (int i = 0; i < 64 && !hs; i++) begin
            mon_tvalid = 1'($urandom_range(0, 1));
            mon_tready = 1'($urandom_range(0, 1));
            if (i == 63) begin
                mon_tvalid = 1'b1;
                mon_tready = 1'b1;
            end
            mon_tuser = u; mon_tlast = l;
            hs = mon_tvalid && mon_tready;
            tick();
        end
        idle_all();
    endtask

    task automatic send_line(input int n, input bit sof, input bit last, input bit stall);
        for (int i = 0; i < n; i++) begin
            if (stall) stall_beat(sof && i == 0, last && i == n - 1);
            else       beat(sof && i == 0, last && i == n - 1);
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        cfg_rd_addr = a;
        tick();
        d = cfg_rd_data;
    endtask

    initial begin
        repeat (3) tick();
        areset = 1'b0;
        check_val("rst_threshold", 32'(threshold), 32'd32);
        check_val("rst_enable", 32'(dpc_enable), 32'd1);
        check_val("rst_irq", 32'(irq), 32'd0);
        check_val("rst_active", 32'(frame_active), 32'd0);
        check_val("rst_rd_data", cfg_rd_data, 32'd0);
        reg_read(2'd0, rd); check_val("rst_ctrl", rd, 32'h1);
        reg_read(2'd1, rd); check_val("rst_thresh", rd, 32'd32);
        reg_read(2'd2, rd); check_val("rst_status", rd, 32'h0);
        reg_read(2'd3, rd); check_val("rst_pos", rd, 32'h0);

        // frame 1: THRESH written mid-frame must not disturb the active value
        beat(1'b1, 1'b0);
        check_val("f1_active", 32'(frame_active), 32'd1);
        send_line(3, 0, 0, 0);
        reg_write(2'd1, 32'h50);
        check_val("f1_thr_held", 32'(threshold), 32'd32);
        send_line(4, 0, 1, 0);
        repeat (3) send_line(8, 0, 1, 0);
        check_val("f1_end_active", 32'(frame_active), 32'd0);
        check_val("f1_end_thr", 32'(threshold), 32'd32);
        reg_read(2'd2, rd); check_val("f1_status", rd, 32'h0001_0008);
        reg_read(2'd1, rd); check_val("f1_thr_pend", rd, 32'h50);

        // frame 2: irq enabled, random stalls
        reg_write(2'd2, 32'h8);
        reg_read(2'd2, rd); check_val("done_cleared", rd, 32'h0001_0000);
        reg_write(2'd0, 32'h3);
        reg_read(2'd0, rd); check_val("ctrl_rw", rd, 32'h3);
        stall_beat(1'b1, 1'b0);
        check_val("f2_thr_commit", 32'(threshold), 32'h50);
        send_line(7, 0, 1, 1);
        repeat (3) send_line(8, 0, 1, 1);
        check_val("f2_irq_lag", 32'(irq), 32'd0);
        tick();
        check_val("f2_irq_rise", 32'(irq), 32'd1);
        reg_write(2'd2, 32'h8);
        check_val("f2_irq_lag_clr", 32'(irq), 32'd1);
        tick();
        check_val("f2_irq_clr", 32'(irq), 32'd0);
        reg_read(2'd2, rd); check_val("f2_status", rd, 32'h0002_0000);

        // frame 3: line-length errors, then a premature SOF
        send_line(8, 1, 1, 0);
        send_line(6, 0, 1, 0);
        reg_read(2'd3, rd); check_val("short_line_pos", rd, 32'h0002_0000);
        reg_read(2'd2, rd); check_val("short_line_stat", rd, 32'h0002_0005);
        send_line(8, 0, 0, 0);
        reg_read(2'd3, rd); check_val("no_tlast_pos", rd, 32'h0003_0000);
        reg_write(2'd2, 32'h4);
        reg_read(2'd2, rd); check_val("len_err_clr", rd, 32'h0002_0001);
        send_line(3, 0, 0, 0);
        beat(1'b1, 1'b0);
        reg_read(2'd3, rd); check_val("early_sof_pos", rd, 32'h0000_0001);
        reg_read(2'd2, rd); check_val("early_sof_stat", rd, 32'h0002_0003);
        send_line(7, 0, 1, 0);
        repeat (3) send_line(8, 0, 1, 0);
        reg_read(2'd2, rd); check_val("f3_status", rd, 32'h0003_000A);
        reg_write(2'd2, 32'hE);
        reg_read(2'd2, rd); check_val("w1c_all", rd, 32'h0003_0000);
        beat(1'b0, 1'b0);
        check_val("nosof_active", 32'(frame_active), 32'd0);
        reg_read(2'd2, rd); check_val("nosof_stat", rd, 32'h0003_0002);

        // frame 4: writes colliding with committing SOF beats
        beat_wr(1'b1, 1'b0, 1'b1, 2'd0, 32'h2);
        check_val("coll_ctrl_en", 32'(dpc_enable), 32'd1);
        check_val("coll_ctrl_thr", 32'(threshold), 32'h50);
        reg_read(2'd0, rd); check_val("coll_ctrl_rd", rd, 32'h2);
        send_line(2, 0, 0, 0);
        beat_wr(1'b1, 1'b0, 1'b1, 2'd1, 32'h11);
        check_val("coll_thr_en", 32'(dpc_enable), 32'd0);
        check_val("coll_thr_thr", 32'(threshold), 32'h50);
        beat(1'b1, 1'b0);
        check_val("next_sof_thr", 32'(threshold), 32'h11);
        reg_write(2'd2, 32'h2);
        reg_read(2'd2, rd); check_val("sof_err_clr", rd, 32'h0003_0001);
        beat_wr(1'b1, 1'b0, 1'b1, 2'd2, 32'h2);
        reg_read(2'd2, rd); check_val("set_beats_w1c", rd, 32'h0003_0003);

        // reset in mid-frame
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check_val("mrst_thr", 32'(threshold), 32'd32);
        check_val("mrst_en", 32'(dpc_enable), 32'd1);
        check_val("mrst_active", 32'(frame_active), 32'd0);
        reg_read(2'd2, rd); check_val("mrst_status", rd, 32'h0);
        beat(1'b0, 1'b0);
        check_val("mrst_need_sof", 32'(frame_active), 32'd0);
        beat(1'b1, 1'b0);
        check_val("mrst_sof", 32'(frame_active), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
